ram32_req_ctrl: RTL and testbench

- Request-side front end for the 32-bit byte-write BRAM (1 read cycle latency, read-enable gated output, per-byte write enables).
- Converts a valid/ready request stream (byte address, write data, write strobe) into the RAM's addr/din/bwe/ren pins.
- Returns read data on a valid/ready response stream through a small buffer, so consumers can stall without losing RAM output.
- Sits directly upstream of the RAM; the consumer of the response stream is any core-side master.

---
 rtl/ram32_pkg.sv | 14 +
 rtl/ram32_resp_fifo.sv | 74 +++++++
 rtl/ram32_resp_fifo_chk.sv | 16 +
 rtl/ram32_req_ctrl.sv | 75 +++++++
 tb/tb_ram32_req_ctrl.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/ram32_pkg.sv
// Shared constants and helpers for the 32-bit byte-write BRAM and its clients.
package ram32_pkg;

  localparam int RAM_DATA_W = 32;
  localparam int RAM_BE_W   = 4;

  localparam logic [RAM_BE_W-1:0] STRB_READ = 4'b0000;

  // Byte address to 32-bit word address; callers truncate to their RAM depth.
  function automatic logic [31:0] byte_to_word_addr(input logic [31:0] byte_addr);
    return byte_addr >> 5'd2;
  endfunction

endpackage

// File: rtl/ram32_resp_fifo.sv
// Synchronous FIFO with arbitrary (non power-of-2) depth; head is the oldest entry.
module ram32_resp_fifo #(
  parameter  int DEPTH = 3,
  parameter  int WIDTH = 32,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [OCC_W-1:0] occ_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : p + PTR_W'(1);
  endfunction

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             push_s, pop_s;

  // A pop on an empty FIFO is dropped; a push while full is dropped and flagged by the checker.
  assign pop_s  = pop_i & (occ_q != OCC_W'(0));
  assign push_s = push_i & (occ_q != OCC_W'(DEPTH));

  always_comb begin
    wr_ptr_d = push_s ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_s ? next_ptr(rd_ptr_q) : rd_ptr_q;
    if (push_s && !pop_s) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (pop_s && !push_s) begin
      occ_d = occ_q - OCC_W'(1);
    end else begin
      occ_d = occ_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= PTR_W'(0);
      rd_ptr_q <= PTR_W'(0);
      occ_q    <= OCC_W'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  assign occ_o  = occ_q;
  assign head_o = mem_q[rd_ptr_q];

  ram32_resp_fifo_chk #(
    .DEPTH (DEPTH),
    .OCC_W (OCC_W)
  ) u_chk (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (push_i),
    .occ_i   (occ_q)
  );

endmodule

// File: rtl/ram32_resp_fifo_chk.sv
// Protocol checks for ram32_resp_fifo, kept apart from the datapath.
module ram32_resp_fifo_chk #(
  parameter int DEPTH = 3,
  parameter int OCC_W = 2
) (
  input logic             clk_i,
  input logic             reset_i,
  input logic             push_i,
  input logic [OCC_W-1:0] occ_i
);

  a_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
    !(push_i && (occ_i == OCC_W'(DEPTH))))
    else $error("ram32_resp_fifo: push while full");

endmodule

// File: rtl/ram32_req_ctrl.sv
// Request-side front end for the byte-write BRAM: maps requests onto RAM pins
// and buffers read data so the response consumer may stall.
module ram32_req_ctrl
  import ram32_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int RESP_DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [RAM_DATA_W-1:0] req_wdata,
  input  logic [RAM_BE_W-1:0]   req_wstrb,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [RAM_DATA_W-1:0] resp_rdata,
  output logic [ADDR_WIDTH-3:0] ram_addr,
  output logic [RAM_DATA_W-1:0] ram_din,
  output logic [RAM_BE_W-1:0]   ram_bwe,
  output logic                  ram_ren,
  input  logic [RAM_DATA_W-1:0] ram_dout
);

  localparam int OCC_W = $clog2(RESP_DEPTH + 1);

  logic             inflight_q, inflight_d;
  logic             fire_s;
  logic [OCC_W-1:0] occ_s;
  logic [OCC_W:0]   pending_s;

  // Reserve a buffer slot for every read not yet popped, including the one on the RAM bus.
  assign pending_s = {1'b0, occ_s} + {{OCC_W{1'b0}}, inflight_q};
  assign req_ready = ~reset & (pending_s < (OCC_W + 1)'(RESP_DEPTH));
  assign fire_s    = req_valid & req_ready;

  assign ram_addr  = (ADDR_WIDTH - 2)'(byte_to_word_addr(32'(req_addr)));
  assign ram_din   = req_wdata;

  always_comb begin
    if (fire_s) begin
      ram_bwe = req_wstrb;
      ram_ren = (req_wstrb == STRB_READ);
    end else begin
      ram_bwe = STRB_READ;
      ram_ren = 1'b0;
    end
    inflight_d = ram_ren;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  ram32_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .WIDTH (RAM_DATA_W)
  ) u_resp_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (inflight_q),
    .din_i   (ram_dout),
    .pop_i   (resp_ready),
    .occ_o   (occ_s),
    .head_o  (resp_rdata)
  );

  assign resp_valid = (occ_s != OCC_W'(0));

endmodule

// File: tb/tb_ram32_req_ctrl.sv
// Directed and randomized bench for ram32_req_ctrl against a transaction-level model.
module tb_ram32_req_ctrl;

  localparam int AW    = 12;
  localparam int DEPTH = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic [3:0]    req_wstrb;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_rdata;
  logic [AW-3:0] ram_addr;
  logic [31:0]   ram_din;
  logic [3:0]    ram_bwe;
  logic          ram_ren;
  logic [31:0]   ram_dout;

  always #5 clk = ~clk;

  ram32_req_ctrl #(.ADDR_WIDTH(AW), .RESP_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_bwe    (ram_bwe),
    .ram_ren    (ram_ren),
    .ram_dout   (ram_dout)
  );

  // BRAM: byte writes, one-cycle read, output held unless ren is high.
  logic [31:0] ram_mem [1024];
  logic [31:0] ram_dout_q;
  always @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < 1024; w++) ram_mem[w] <= 32'h0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (ram_bwe[b]) ram_mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
    end
    if (ram_ren) ram_dout_q <= ram_mem[ram_addr];
  end
  assign ram_dout = ram_dout_q;

  // Reference model: memory image plus outstanding reads (data, accept cycle).
  logic [31:0] ref_mem [1024];
  logic [31:0] exp_q [$];
  int          acc_q [$];
  int          cyc;
  int          vectors;
  int          miscompares;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input logic v, input logic [AW-1:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic rr, output logic dut_fire);
    logic exp_rdy, exp_fire, exp_vld;
    req_valid  = v;
    req_addr   = a;
    req_wdata  = d;
    req_wstrb  = s;
    resp_ready = rr;
    @(negedge clk);
    exp_rdy  = !reset && (exp_q.size() < DEPTH);
    exp_fire = v && exp_rdy;
    exp_vld  = !reset && (exp_q.size() > 0) && (acc_q.size() > 0) && (acc_q[0] <= cyc - 2);
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (!reset) begin
      chk("resp_valid", 32'(resp_valid), 32'(exp_vld));
      if (exp_vld) chk("resp_rdata", resp_rdata, exp_q[0]);
    end
    chk("ram_bwe", 32'(ram_bwe), exp_fire ? 32'(s) : 32'h0);
    chk("ram_ren", 32'(ram_ren), 32'(exp_fire && (s == 4'h0)));
    chk("ram_addr", 32'(ram_addr), 32'(a[AW-1:2]));
    chk("ram_din", ram_din, d);
    dut_fire = v & req_ready;
    if (reset) begin
      exp_q.delete();
      acc_q.delete();
    end else begin
      if (exp_vld && rr) begin
        void'(exp_q.pop_front());
        void'(acc_q.pop_front());
      end
      if (exp_fire) begin
        if (s == 4'h0) begin
          exp_q.push_back(ref_mem[a[AW-1:2]]);
          acc_q.push_back(cyc);
        end else begin
          for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[a[AW-1:2]][8*b +: 8] = d[8*b +: 8];
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  logic f;
  int   n;

  initial begin
    vectors = 0; miscompares = 0; cyc = 0;
    for (int w = 0; w < 1024; w++) ref_mem[w] = 32'h0;
    reset = 1'b1;
    req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0; resp_ready = 1'b0;
    #1;
    step(1'b1, 12'h010, 32'h0, 4'h0, 1'b1, f);
    step(1'b0, 12'h000, 32'h0, 4'h0, 1'b1, f);
    reset = 1'b0;
    step(1'b0, 12'h000, 32'h0, 4'h0, 1'b1, f);

    // Write then immediate read of the same word.
    step(1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 1'b1, f);
    step(1'b1, 12'h010, 32'h0, 4'h0, 1'b1, f);
    for (int k = 0; k < 3; k++) step(1'b0, 12'h000, 32'h0, 4'h0, 1'b1, f);

    // Partial-strobe merge.
    step(1'b1, 12'h020, 32'h11223344, 4'hF, 1'b1, f);
    step(1'b1, 12'h020, 32'hAABBCCDD, 4'b0101, 1'b1, f);
    step(1'b1, 12'h020, 32'h0, 4'h0, 1'b1, f);
    for (int k = 0; k < 3; k++) step(1'b0, 12'h000, 32'h0, 4'h0, 1'b1, f);

    // Preload words 0..15 with their index, then 16 back-to-back reads.
    for (int i = 0; i < 16; i++) step(1'b1, 12'(i * 4), 32'(i), 4'hF, 1'b1, f);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 12'(i * 4), 32'h0, 4'h0, 1'b1, f);
      chk("b2b_accept", 32'(f), 32'h1);
    end
    for (int k = 0; k < 4; k++) step(1'b0, 12'h000, 32'h0, 4'h0, 1'b1, f);

    // Same reads with the consumer stalled, then released.
    n = 0;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 12'(n * 4), 32'h0, 4'h0, 1'b0, f);
      if (f) n++;
    end
    chk("stall_accepts", 32'(n), 32'd3);
    for (int k = 0; k < 60 && n < 16; k++) begin
      step(1'b1, 12'(n * 4), 32'h0, 4'h0, 1'b1, f);
      if (f) n++;
    end
    chk("stall_all_issued", 32'(n), 32'd16);
    for (int k = 0; k < 8; k++) step(1'b0, 12'h000, 32'h0, 4'h0, 1'b1, f);

    // Unaligned byte address selects the containing word.
    step(1'b1, 12'h013, 32'h0, 4'h0, 1'b1, f);
    step(1'b1, 12'h010, 32'h0, 4'h0, 1'b1, f);
    for (int k = 0; k < 4; k++) step(1'b0, 12'h000, 32'h0, 4'h0, 1'b1, f);

    // Two buffered responses plus one in flight, then reset.
    step(1'b1, 12'h000, 32'h0, 4'h0, 1'b0, f);
    step(1'b1, 12'h004, 32'h0, 4'h0, 1'b0, f);
    step(1'b0, 12'h000, 32'h0, 4'h0, 1'b0, f);
    step(1'b1, 12'h008, 32'h0, 4'h0, 1'b0, f);
    reset = 1'b1;
    step(1'b0, 12'h000, 32'h0, 4'h0, 1'b0, f);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) step(1'b0, 12'h000, 32'h0, 4'h0, 1'b1, f);

    // Randomized traffic; the reset above cleared the RAM, so resync the model image.
    for (int w = 0; w < 1024; w++) ref_mem[w] = 32'h0;
    for (int k = 0; k < 300; k++) begin
      logic [3:0] s;
      s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      step(1'($urandom_range(0, 1)), 12'($urandom_range(0, 255)), $urandom, s,
           1'($urandom_range(0, 3) != 0), f);
    end
    for (int k = 0; k < 10; k++) step(1'b0, 12'h000, 32'h0, 4'h0, 1'b1, f);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
